// File: rtl/scanner_pkg.sv
// Shared definitions for the scanner control stage: state codes (also
// consumed by counterCtrl) and default timing constants.
package scanner_pkg;

    typedef enum logic [2:0] {
        LOW_POWER = 3'b000,
        STANDBY   = 3'b001,
        SCANNING  = 3'b010,
        IDLE      = 3'b011,
        XFER      = 3'b100,
        FLUSH     = 3'b101
    } state_e;

    localparam int unsigned DEF_SCAN_CYCLES  = 10;
    localparam int unsigned DEF_FLUSH_CYCLES = 6;

    // States in which the scanner is actively moving data.
    function automatic logic is_busy(logic [2:0] s);
        return (s == SCANNING) || (s == XFER) || (s == FLUSH);
    endfunction

endpackage

// File: rtl/buf_level_ctr.sv
// 4-bit saturating up/down fill-level counter. The at_* flags describe the
// value being loaded on the next edge so the FSM can react in the same cycle.
module buf_level_ctr #(
    parameter int unsigned MAX = 10
) (
    input  logic       clk_i,
    input  logic       inc_i,
    input  logic       dec_i,
    input  logic       clr_i,
    output logic [3:0] level_o,
    output logic       at_half_o,
    output logic       at_max_o
);

    logic [3:0] level_q, level_d;

    // Next level: clear wins, then saturating increment, then saturating decrement.
    always_comb begin
        level_d = level_q;
        if (clr_i)
            level_d = 4'd0;
        else if (inc_i && (level_q != 4'(MAX)))
            level_d = level_q + 4'd1;
        else if (dec_i && (level_q != 4'd0))
            level_d = level_q - 4'd1;
    end

    // Level register; reset arrives through clr_i.
    always_ff @(posedge clk_i) begin
        level_q <= level_d;
    end

    assign level_o   = level_q;
    assign at_half_o = (level_d == 4'(MAX / 2));
    assign at_max_o  = (level_d == 4'(MAX));

endmodule

// File: rtl/scanner_fsm.sv
// Scanner control FSM: sequences power/scan/transfer/flush, owns the flush
// timer and the registered handshake pulses. Fill level lives in buf_level_ctr.
module scanner_fsm
    import scanner_pkg::*;
#(
    parameter int unsigned SCAN_CYCLES  = DEF_SCAN_CYCLES,
    parameter int unsigned FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       power_up,
    input  logic       start_scan,
    input  logic       xfer_req,
    input  logic       flush_req,
    output logic [2:0] state,
    output logic [3:0] buf_level,
    output logic       half_full,
    output logic       xfer_done,
    output logic       busy
);

    logic [2:0] state_q, state_d;
    logic [3:0] timer_q, timer_d;
    logic       half_full_q, half_full_d;
    logic       xfer_done_q, xfer_done_d;
    logic       busy_q, busy_d;
    logic       inc, dec, clr;
    logic       at_half, at_max;
    logic [3:0] level;

    // Counter controls depend only on current state and inputs (no loop via state_d).
    assign inc = (state_q == SCANNING) && !flush_req;
    assign dec = (state_q == XFER);
    assign clr = reset || (flush_req &&
                 ((state_q == STANDBY) || (state_q == SCANNING) || (state_q == IDLE)));

    buf_level_ctr #(.MAX(SCAN_CYCLES)) u_lvl (
        .clk_i    (clk),
        .inc_i    (inc),
        .dec_i    (dec),
        .clr_i    (clr),
        .level_o  (level),
        .at_half_o(at_half),
        .at_max_o (at_max)
    );

    // State register plus registered outputs and flush timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= LOW_POWER;
            timer_q     <= 4'd0;
            half_full_q <= 1'b0;
            xfer_done_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            half_full_q <= half_full_d;
            xfer_done_q <= xfer_done_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic; unused codes fall back to LOW_POWER.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOW_POWER: if (power_up) state_d = STANDBY;
            STANDBY: begin
                if (flush_req)       state_d = FLUSH;
                else if (start_scan) state_d = SCANNING;
            end
            SCANNING: begin
                if (flush_req)   state_d = FLUSH;
                else if (at_max) state_d = IDLE;
            end
            IDLE: begin
                if (flush_req)     state_d = FLUSH;
                else if (xfer_req) state_d = XFER;
            end
            XFER:  if (level == 4'd0) state_d = LOW_POWER;
            FLUSH: if (timer_q == 4'(FLUSH_CYCLES - 1)) state_d = LOW_POWER;
            default: state_d = LOW_POWER;
        endcase
    end

    // Output/timer next values; pulses are computed for the cycle after this edge.
    always_comb begin
        half_full_d = inc && at_half;
        xfer_done_d = dec && (level == 4'd1);
        busy_d      = is_busy(state_d);
        timer_d     = ((state_q == FLUSH) && (state_d == FLUSH)) ? timer_q + 4'd1 : 4'd0;
    end

    assign state     = state_q;
    assign buf_level = level;
    assign half_full = half_full_q;
    assign xfer_done = xfer_done_q;
    assign busy      = busy_q;

endmodule
